// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and instruction-memory-side signals of the direct-mapped I-cache.
// The slave modport is the cache; the master modport is its environment.
interface icache_direct_mapped_if #(
  parameter int ADDR_W = 30
);
  logic              proc_read;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0]       proc_rdata;
  logic              proc_stall;
  logic              mem_read;
  logic [ADDR_W-3:0] mem_addr;
  logic [127:0]      mem_rdata;
  logic              mem_ready;

  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache, zero-latency hits, 4-word block fills.
// Define ICACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_direct_mapped #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = 30
) (
  input  logic clk,
  input  logic rst,
  icache_direct_mapped_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int IDX   = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - 2 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]  tag_arr  [NUM_BLOCKS];
  logic [127:0]      data_arr [NUM_BLOCKS];
  logic [ADDR_W-3:0] miss_addr_r;
  logic              mem_read_r;

  logic [1:0]        offset;
  logic [IDX-1:0]    index;
  logic [TAG_W-1:0]  tag;
  logic              lookup_hit;
  logic              hit;
  logic              miss;

  assign offset     = bus.proc_addr[1:0];
  assign index      = bus.proc_addr[IDX+1:2];
  assign tag        = bus.proc_addr[ADDR_W-1:IDX+2];
  assign lookup_hit = valid[index] && (tag_arr[index] == tag);
  assign hit        = (state == IDLE) && bus.proc_read && lookup_hit;
  assign miss       = (state == IDLE) && bus.proc_read && !lookup_hit;

  // Hit data and stall are combinational so a hit costs no cycle.
  always_comb begin
    bus.proc_rdata = '0;
    bus.proc_stall = (state == FETCH) || miss;
    if (hit) bus.proc_rdata = data_arr[index][{offset, 5'b0} +: 32];
  end

  assign bus.mem_read = mem_read_r;
  assign bus.mem_addr = miss_addr_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      miss_addr_r <= '0;
      mem_read_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            miss_addr_r <= bus.proc_addr[ADDR_W-1:2];
            mem_read_r  <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            valid[miss_addr_r[IDX-1:0]] <= 1'b1;
            mem_read_r                  <= 1'b0;
            state                       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; a fill is suppressed during reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == FETCH) && bus.mem_ready) begin
      data_arr[miss_addr_r[IDX-1:0]] <= bus.mem_rdata;
      tag_arr[miss_addr_r[IDX-1:0]]  <= miss_addr_r[ADDR_W-3:IDX];
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
      if (miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed self-checking bench for icache_direct_mapped (NUM_BLOCKS=8, ADDR_W=30).
module tb_icache_direct_mapped;
  localparam int ADDR_W = 30;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  icache_direct_mapped_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_direct_mapped #(.NUM_BLOCKS(8), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a read that must miss, answer it after nready FETCH cycles, check the stall window.
  task automatic do_miss(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-3:0] exp_maddr,
                         input logic [127:0] data, input int nready);
    int stalls = 0;
    bus.proc_read = 1'b1;
    bus.proc_addr = addr;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL miss_detect addr=%0d stall=%b expected=1", addr, bus.proc_stall);
    end
    for (int c = 0; c < nready + 5; c++) begin
      if (bus.proc_stall !== 1'b1) break;
      stalls++;
      checks++;
      if (c == 0) begin
        if (bus.mem_read !== 1'b0) begin
          errors++;
          $display("FAIL idle_mem_read addr=%0d mem_read=%b expected=0", addr, bus.mem_read);
        end
      end else begin
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== exp_maddr) begin
          errors++;
          $display("FAIL fetch_req cyc=%0d mem_read=%b mem_addr=%0d expected 1/%0d",
                   c, bus.mem_read, bus.mem_addr, exp_maddr);
        end
        if (c == nready) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = data;
        end
      end
      tick();
      bus.mem_ready = 1'b0;
      #1;
    end
    checks++;
    if (stalls != nready + 1) begin
      errors++;
      $display("FAIL stall_length addr=%0d stalls=%0d expected=%0d", addr, stalls, nready + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.proc_read = 1'b0;
    bus.proc_addr = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_addr !== '0 || bus.proc_stall !== 1'b0 ||
        bus.proc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs mem_read=%b mem_addr=%0d stall=%b rdata=%h expected 0/0/0/0",
               bus.mem_read, bus.mem_addr, bus.proc_stall, bus.proc_rdata);
    end
  endtask

  task automatic test_cold_miss();
    tick();
    do_miss(30'd0, 28'd0, {32'h44, 32'h33, 32'h22, 32'h11}, 3);
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h11) begin
      errors++;
      $display("FAIL cold_fill_hit stall=%b rdata=%h expected 0/00000011",
               bus.proc_stall, bus.proc_rdata);
    end
  endtask

  task automatic test_same_block_hits();
    logic [31:0] exp_words [3];
    exp_words[0] = 32'h22;
    exp_words[1] = 32'h33;
    exp_words[2] = 32'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.proc_addr = 30'(i + 1);
      #1;
      checks++;
      if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== exp_words[i] || bus.mem_read !== 1'b0) begin
        errors++;
        $display("FAIL block_hit addr=%0d stall=%b rdata=%h mem_read=%b expected 0/%h/0",
                 i + 1, bus.proc_stall, bus.proc_rdata, bus.mem_read, exp_words[i]);
      end
    end
    tick();
    bus.proc_read = 1'b0;
    #1;
`ifdef ICACHE_PERF_CNT_EN
    checks++;
    if (hit_cnt !== 32'd4 || miss_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_counts hit_cnt=%0d miss_cnt=%0d expected 4/1", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_conflict();
    tick();
    do_miss(30'd32, 28'd8, {32'hD3, 32'hC2, 32'hB1, 32'hA0}, 1);
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'hA0) begin
      errors++;
      $display("FAIL conflict_fill_hit stall=%b rdata=%h expected 0/000000a0",
               bus.proc_stall, bus.proc_rdata);
    end
    tick();
    do_miss(30'd0, 28'd0, {32'h44, 32'h33, 32'h22, 32'h11}, 2);
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h11) begin
      errors++;
      $display("FAIL evict_refill_hit stall=%b rdata=%h expected 0/00000011",
               bus.proc_stall, bus.proc_rdata);
    end
    bus.proc_read = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    tick();
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'd4;
    tick();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'd1) begin
      errors++;
      $display("FAIL midfill_fetch mem_read=%b mem_addr=%0d expected 1/1", bus.mem_read, bus.mem_addr);
    end
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {4{32'hDEADBEEF}};
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL midfill_mem_read mem_read=%b expected=0", bus.mem_read);
    end
    checks++;
    if (bus.proc_stall !== 1'b1 || bus.proc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midfill_no_write stall=%b rdata=%h expected 1/00000000",
               bus.proc_stall, bus.proc_rdata);
    end
    bus.proc_addr = 30'd0;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL midfill_valid_clear stall=%b expected=1", bus.proc_stall);
    end
    bus.proc_read = 1'b0;
  endtask

  task automatic test_idle_stray_ready();
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.mem_ready = c[0];
      bus.mem_rdata = {4{32'hCAFEF00D}};
      #1;
      checks++;
      if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.proc_rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d stall=%b mem_read=%b rdata=%h expected 0/0/0",
                 c, bus.proc_stall, bus.mem_read, bus.proc_rdata);
      end
    end
    tick();
    bus.mem_ready = 1'b0;
    do_miss(30'd0, 28'd0, {32'h44, 32'h33, 32'h22, 32'h11}, 2);
    bus.proc_read = 1'b0;
  endtask

  task automatic test_index_wrap();
    tick();
    do_miss(30'd31, 28'd7, {32'h7003, 32'h7002, 32'h7001, 32'h7000}, 1);
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h7003) begin
      errors++;
      $display("FAIL wrap_fill_hit stall=%b rdata=%h expected 0/00007003",
               bus.proc_stall, bus.proc_rdata);
    end
    tick();
    bus.proc_addr = 30'd28;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h7000) begin
      errors++;
      $display("FAIL wrap_word0_hit stall=%b rdata=%h expected 0/00007000",
               bus.proc_stall, bus.proc_rdata);
    end
    bus.proc_addr = 30'd0;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h11) begin
      errors++;
      $display("FAIL wrap_line0_kept stall=%b rdata=%h expected 0/00000011",
               bus.proc_stall, bus.proc_rdata);
    end
    bus.proc_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_block_hits();
    test_conflict();
    test_reset_mid_fill();
    test_idle_stray_ready();
    test_index_wrap();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
